// File: rtl/esfa_op_sequencer_if.sv
// Command, response and array-side signal bundle for the ESFA op sequencer.
// The slave modport is the sequencer's view; master is the upstream/array environment.
interface esfa_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_handle;
  logic [7:0] cmd_index;
  logic [7:0] cmd_value;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic [7:0] rsp_value;

  logic [7:0] arr_selector;
  logic [7:0] arr_queried_handle;
  logic [7:0] arr_new_index;
  logic [7:0] arr_new_value;
  logic       arr_result_bool;
  logic [7:0] arr_result_value;

  modport slave (
    input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value,
    input  rsp_ready,
    input  arr_result_bool, arr_result_value,
    output cmd_ready,
    output rsp_valid, rsp_hit, rsp_value,
    output arr_selector, arr_queried_handle, arr_new_index, arr_new_value
  );

  modport master (
    output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value,
    output rsp_ready,
    output arr_result_bool, arr_result_value,
    input  cmd_ready,
    input  rsp_valid, rsp_hit, rsp_value,
    input  arr_selector, arr_queried_handle, arr_new_index, arr_new_value
  );
endinterface

// File: rtl/esfa_op_sequencer.sv
// Front-end sequencer for the 8-cell ESFA array: expands LOOKUP/UPDATE commands
// into per-cycle array selector sequences and returns one response per command.
module esfa_op_sequencer (
  input  logic                        clk,
  input  logic                        reset,
  esfa_op_sequencer_if.slave          bus_io,
  output logic                        busy_o
);

  localparam logic [7:0] SEL_NOP       = 8'd0;
  localparam logic [7:0] SEL_LOOKUP    = 8'd1;
  localparam logic [7:0] SEL_FIND_CODE = 8'd2;
  localparam logic [7:0] SEL_ALLOC     = 8'd5;
  localparam logic [7:0] SEL_FIND_RANK = 8'd6;
  localparam logic [7:0] SEL_WRITE     = 8'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CODE,
    S_RANK,
    S_ALLOC,
    S_WRITE,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cmdHandle_q, cmdHandle_d;
  logic [7:0] cmdIndex_q, cmdIndex_d;
  logic [7:0] cmdValue_q, cmdValue_d;
  logic       allocOk_q, allocOk_d;
  logic [7:0] allocH_q, allocH_d;
  logic       rspHit_q, rspHit_d;
  logic [7:0] rspValue_q, rspValue_d;
  logic       cmdReady;

  // Holding off cmd_ready while reset is asserted keeps upstream from seeing a false accept.
  assign cmdReady = (state_q == S_IDLE) && reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmdHandle_q <= 8'd0;
      cmdIndex_q  <= 8'd0;
      cmdValue_q  <= 8'd0;
      allocOk_q   <= 1'b0;
      allocH_q    <= 8'd0;
      rspHit_q    <= 1'b0;
      rspValue_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmdHandle_q <= cmdHandle_d;
      cmdIndex_q  <= cmdIndex_d;
      cmdValue_q  <= cmdValue_d;
      allocOk_q   <= allocOk_d;
      allocH_q    <= allocH_d;
      rspHit_q    <= rspHit_d;
      rspValue_q  <= rspValue_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmdHandle_d = cmdHandle_q;
    cmdIndex_d  = cmdIndex_q;
    cmdValue_d  = cmdValue_q;
    allocOk_d   = allocOk_q;
    allocH_d    = allocH_q;
    rspHit_d    = rspHit_q;
    rspValue_d  = rspValue_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus_io.cmd_valid && cmdReady) begin
          cmdHandle_d = bus_io.cmd_handle;
          cmdIndex_d  = bus_io.cmd_index;
          cmdValue_d  = bus_io.cmd_value;
          rspHit_d    = 1'b0;
          rspValue_d  = 8'd0;
          unique case (bus_io.cmd_op)
            2'b00:   state_d = S_LOOKUP;
            2'b01:   state_d = S_CODE;
            default: state_d = S_RESP;
          endcase
        end
      end
      S_LOOKUP: begin
        rspHit_d   = bus_io.arr_result_bool;
        rspValue_d = bus_io.arr_result_value;
        state_d    = S_RESP;
      end
      S_CODE: state_d = S_RANK;
      S_RANK: state_d = S_ALLOC;
      S_ALLOC: begin
        allocOk_d = bus_io.arr_result_bool;
        allocH_d  = bus_io.arr_result_value;
        // A full array skips the write entirely and reports a miss.
        if (bus_io.arr_result_bool) begin
          state_d = S_WRITE;
        end else begin
          rspHit_d   = 1'b0;
          rspValue_d = 8'd0;
          state_d    = S_RESP;
        end
      end
      S_WRITE: begin
        rspHit_d   = 1'b1;
        rspValue_d = allocH_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (bus_io.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_io.arr_selector       = SEL_NOP;
    bus_io.arr_queried_handle = 8'd0;
    bus_io.arr_new_index      = 8'd0;
    bus_io.arr_new_value      = 8'd0;

    if (state_q != S_IDLE && state_q != S_RESP) begin
      bus_io.arr_queried_handle = cmdHandle_q;
      bus_io.arr_new_index      = cmdIndex_q;
      bus_io.arr_new_value      = cmdValue_q;
    end

    unique case (state_q)
      S_LOOKUP: bus_io.arr_selector = SEL_LOOKUP;
      S_CODE:   bus_io.arr_selector = SEL_FIND_CODE;
      S_RANK:   bus_io.arr_selector = SEL_FIND_RANK;
      S_ALLOC:  bus_io.arr_selector = SEL_ALLOC;
      S_WRITE:  bus_io.arr_selector = SEL_WRITE;
      default:  bus_io.arr_selector = SEL_NOP;
    endcase
  end

  assign bus_io.cmd_ready = cmdReady;
  assign bus_io.rsp_valid = (state_q == S_RESP);
  assign bus_io.rsp_hit   = rspHit_q;
  assign bus_io.rsp_value = rspValue_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Self-checking bench for esfa_op_sequencer: table-driven ops with a response
// scoreboard, plus hand-written reset, backpressure and mid-op reset sequences.
module tb_esfa_op_sequencer;

  logic clk;
  logic reset;
  logic busy;

  esfa_op_sequencer_if bus ();

  esfa_op_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus),
    .busy_o (busy)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] handle;
    logic [7:0] index;
    logic [7:0] value;
    logic       arrBool;
    logic [7:0] arrVal;
    logic       expHit;
    logic [7:0] expValue;
    int         expLat;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [7:0] value;
    int         lat;
  } expRsp_t;

  int      checks = 0;
  int      errors = 0;
  expRsp_t expQ[$];
  vec_t    vecs[7];

  logic       modelBool;
  logic [7:0] modelVal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array stand-in: answers lookup/alloc selectors from the model, junk otherwise.
  always_comb begin
    bus.arr_result_bool  = 1'b1;
    bus.arr_result_value = 8'hEE;
    if (bus.arr_selector == 8'd1 || bus.arr_selector == 8'd5) begin
      bus.arr_result_bool  = modelBool;
      bus.arr_result_value = modelVal;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int hold, input bit earlyReady);
    logic [7:0] seenSel[$];
    logic [7:0] expSel[$];
    expRsp_t    e;
    int         lat;
    int         n;

    @(negedge clk);
    checkOutput("cmd_ready idle", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = v.op;
    bus.cmd_handle = v.handle;
    bus.cmd_index  = v.index;
    bus.cmd_value  = v.value;
    modelBool      = v.arrBool;
    modelVal       = v.arrVal;
    expQ.push_back('{v.expHit, v.expValue, v.expLat});
    if (v.op == 2'b00) begin
      expSel.push_back(8'd1);
    end else if (v.op == 2'b01) begin
      expSel.push_back(8'd2);
      expSel.push_back(8'd6);
      expSel.push_back(8'd5);
      if (v.arrBool) expSel.push_back(8'd7);
    end

    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b11;
    bus.cmd_handle = ~v.handle;
    bus.cmd_index  = ~v.index;
    bus.cmd_value  = ~v.value;
    if (earlyReady) bus.rsp_ready = 1'b1;

    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      seenSel.push_back(bus.arr_selector);
      checkOutput("busy while active", {31'd0, busy}, 32'd1);
      if (bus.arr_selector != 8'd0)
        checkOutput("arr handle", {24'd0, bus.arr_queried_handle}, {24'd0, v.handle});
      if (bus.arr_selector == 8'd7) begin
        checkOutput("write index", {24'd0, bus.arr_new_index}, {24'd0, v.index});
        checkOutput("write value", {24'd0, bus.arr_new_value}, {24'd0, v.value});
      end
    end

    if (expQ.size() == 0) begin
      checkOutput("scoreboard empty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();

    if (lat == 0) begin
      checkOutput("rsp timeout", 32'd0, 32'd1);
      bus.rsp_ready = 1'b0;
      return;
    end

    checkOutput("rsp latency", lat, e.lat);
    checkOutput("rsp hit", {31'd0, bus.rsp_hit}, {31'd0, e.hit});
    checkOutput("rsp value", {24'd0, bus.rsp_value}, {24'd0, e.value});
    checkOutput("sel count", seenSel.size(), expSel.size());
    n = (seenSel.size() < expSel.size()) ? seenSel.size() : expSel.size();
    for (int i = 0; i < n; i++)
      checkOutput("sel sequence", {24'd0, seenSel[i]}, {24'd0, expSel[i]});

    // Backpressure: response must hold and new commands must be ignored.
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      @(negedge clk);
      checkOutput("hold rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("hold rsp_hit", {31'd0, bus.rsp_hit}, {31'd0, e.hit});
      checkOutput("hold rsp_value", {24'd0, bus.rsp_value}, {24'd0, e.value});
      checkOutput("hold cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.cmd_valid = 1'b0;

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("post rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("post cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("post busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b00, 8'h03, 8'h04, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A, 2};
    vecs[1] = '{2'b00, 8'h00, 8'hFF, 8'h12, 1'b0, 8'h11, 1'b0, 8'h11, 2};
    vecs[2] = '{2'b01, 8'h01, 8'h02, 8'h33, 1'b1, 8'h06, 1'b1, 8'h06, 5};
    vecs[3] = '{2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h77, 1'b0, 8'h00, 4};
    vecs[4] = '{2'b10, 8'h44, 8'h55, 8'h66, 1'b1, 8'h99, 1'b0, 8'h00, 1};
    vecs[5] = '{2'b11, 8'hAA, 8'hBB, 8'hCC, 1'b1, 8'h99, 1'b0, 8'h00, 1};
    vecs[6] = '{2'b01, 8'h80, 8'h7F, 8'hFE, 1'b1, 8'hFF, 1'b1, 8'hFF, 5};

    reset          = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'b00;
    bus.cmd_handle = 8'h01;
    bus.cmd_index  = 8'h01;
    bus.cmd_value  = 8'h01;
    bus.rsp_ready  = 1'b0;
    modelBool      = 1'b0;
    modelVal       = 8'h00;

    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("reset selector", {24'd0, bus.arr_selector}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
    end
    bus.cmd_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    checkOutput("release cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("release rsp_hit", {31'd0, bus.rsp_hit}, 32'd0);
    checkOutput("release rsp_value", {24'd0, bus.rsp_value}, 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i], 0, 1'b0);

    applyStimulus(vecs[0], 5, 1'b0);
    applyStimulus(vecs[2], 5, 1'b0);
    applyStimulus(vecs[2], 0, 1'b1);
    applyStimulus(vecs[4], 0, 1'b1);

    // Reset landing in the RANK cycle must drop the op without a response.
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 2'b01;
    bus.cmd_handle = 8'h09;
    bus.cmd_index  = 8'h0A;
    bus.cmd_value  = 8'h0B;
    modelBool      = 1'b1;
    modelVal       = 8'h03;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid-op code sel", {24'd0, bus.arr_selector}, 32'd2);
    @(negedge clk);
    checkOutput("mid-op rank sel", {24'd0, bus.arr_selector}, 32'd6);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-op reset sel", {24'd0, bus.arr_selector}, 32'd0);
    checkOutput("mid-op reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid-op reset cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("mid-op no rsp", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("mid-op no write", {31'd0, bus.arr_selector == 8'd7}, 32'd0);
    end
    applyStimulus(vecs[0], 0, 1'b0);

    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
